// File: rtl/sd_ctrl_pkg.sv
// Shared types and constants for the SPI SD block scheduler.
package sd_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StFinish
    } sd_state_e;

    // One SDSC block is 512 bytes
    localparam int unsigned SD_BLOCK_SHIFT = 9;

    localparam int unsigned DEF_ADDR_W    = 16;
    localparam int unsigned DEF_SD_ADDR_W = 32;
    localparam int unsigned DEF_CNT_W     = 4;
    localparam int unsigned DEF_TIMEOUT_W = 20;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-served port loses a tie.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic served,
    output logic grant0,
    output logic grant1
);

    logic last_q;

    // Resets to port 1 so port 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= served;
        end
    end

    always_comb begin
        grant0 = req0 & (~req1 | last_q);
        grant1 = req1 & (~req0 | ~last_q);
    end

endmodule

// File: rtl/sd_block_scheduler.sv
// Arbitrates two block requesters and sequences per-block SD transfers with a watchdog.
module sd_block_scheduler
    import sd_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned SD_ADDR_W = DEF_SD_ADDR_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic                 req0_write,
    input  logic [ADDR_W-1:0]    req0_block,
    input  logic [CNT_W-1:0]     req0_count,
    input  logic                 req1_valid,
    input  logic                 req1_write,
    input  logic [ADDR_W-1:0]    req1_block,
    input  logic [CNT_W-1:0]     req1_count,
    output logic                 req0_grant,
    output logic                 req1_grant,
    output logic                 req0_done,
    output logic                 req1_done,
    output logic                 req0_error,
    output logic                 req1_error,
    output logic                 sd_start,
    output logic                 sd_write,
    output logic [SD_ADDR_W-1:0] sd_addr,
    input  logic                 sd_done,
    input  logic                 sd_error,
    output logic                 busy
);

    sd_state_e            state;
    logic                 port_q;
    logic                 write_q;
    logic [ADDR_W-1:0]    block_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     idx_q;
    logic [TIMEOUT_W-1:0] wd_q;

    logic                 arb_g0;
    logic                 arb_g1;
    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_block;
    logic [CNT_W-1:0]     sel_count;
    logic [CNT_W-1:0]     idx_next;
    logic [ADDR_W-1:0]    issue_block;
    logic [SD_ADDR_W-1:0] issue_ext;
    logic [SD_ADDR_W-1:0] issue_addr;
    logic                 finish;
    logic                 abort;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .update (state == StFinish),
        .served (port_q),
        .grant0 (arb_g0),
        .grant1 (arb_g1)
    );

    always_comb begin
        sel_write = arb_g1 ? req1_write : req0_write;
        sel_block = arb_g1 ? req1_block : req0_block;
        sel_count = arb_g1 ? req1_count : req0_count;
        idx_next  = idx_q + 1'b1;
        // Block index wraps within ADDR_W before being scaled to bytes
        issue_block = (state == StIdle) ? sel_block : block_q + ADDR_W'(idx_next);
        issue_ext   = SD_ADDR_W'(issue_block);
        issue_addr  = issue_ext << SD_BLOCK_SHIFT;
        // A completion beats a watchdog expiry in the same cycle
        finish = sd_done ? (sd_error || (idx_q == count_q)) : (wd_q == TIMEOUT_W'(1));
        abort  = sd_done ? sd_error : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            port_q     <= 1'b0;
            write_q    <= 1'b0;
            block_q    <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            wd_q       <= '0;
            req0_grant <= 1'b0;
            req1_grant <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_error <= 1'b0;
            req1_error <= 1'b0;
            sd_start   <= 1'b0;
            sd_write   <= 1'b0;
            sd_addr    <= '0;
            busy       <= 1'b0;
        end else begin
            req0_grant <= 1'b0;
            req1_grant <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_error <= 1'b0;
            req1_error <= 1'b0;
            sd_start   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (arb_g0 || arb_g1) begin
                        port_q     <= arb_g1;
                        write_q    <= sel_write;
                        block_q    <= sel_block;
                        count_q    <= sel_count;
                        idx_q      <= '0;
                        req0_grant <= arb_g0;
                        req1_grant <= arb_g1;
                        sd_start   <= 1'b1;
                        sd_write   <= sel_write;
                        sd_addr    <= issue_addr;
                        wd_q       <= '1;
                        busy       <= 1'b1;
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    wd_q  <= wd_q - 1'b1;
                    state <= StWait;
                end
                StWait: begin
                    wd_q <= wd_q - 1'b1;
                    if (finish) begin
                        req0_done  <= ~port_q;
                        req1_done  <= port_q;
                        req0_error <= ~port_q & abort;
                        req1_error <= port_q & abort;
                        state      <= StFinish;
                    end else if (sd_done) begin
                        idx_q    <= idx_next;
                        sd_start <= 1'b1;
                        sd_write <= write_q;
                        sd_addr  <= issue_addr;
                        wd_q     <= '1;
                        state    <= StIssue;
                    end
                end
                StFinish: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_scheduler.sv
// Directed self-checking bench for sd_block_scheduler (watchdog shortened to 4 bits).
module tb_sd_block_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [15:0] req0_block, req1_block;
    logic [3:0]  req0_count, req1_count;
    logic        req0_grant, req1_grant, req0_done, req1_done, req0_error, req1_error;
    logic        sd_start, sd_write, sd_done, sd_error, busy;
    logic [31:0] sd_addr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] addr_log [0:15];

    always #5 clk = ~clk;

    sd_block_scheduler #(
        .ADDR_W    (16),
        .SD_ADDR_W (32),
        .CNT_W     (4),
        .TIMEOUT_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_block (req0_block),
        .req0_count (req0_count),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_block (req1_block),
        .req1_count (req1_count),
        .req0_grant (req0_grant),
        .req1_grant (req1_grant),
        .req0_done  (req0_done),
        .req1_done  (req1_done),
        .req0_error (req0_error),
        .req1_error (req1_error),
        .sd_start   (sd_start),
        .sd_write   (sd_write),
        .sd_addr    (sd_addr),
        .sd_done    (sd_done),
        .sd_error   (sd_error),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic port, input logic v, input logic wr,
                           input logic [15:0] blk, input logic [3:0] cnt);
        if (!port) begin
            req0_valid = v; req0_write = wr; req0_block = blk; req0_count = cnt;
        end else begin
            req1_valid = v; req1_write = wr; req1_block = blk; req1_count = cnt;
        end
    endtask

    function automatic logic grant_of(input logic p);
        return p ? req1_grant : req0_grant;
    endfunction

    function automatic logic done_of(input logic p);
        return p ? req1_done : req0_done;
    endfunction

    function automatic logic error_of(input logic p);
        return p ? req1_error : req0_error;
    endfunction

    // Wait up to two cycles in WAIT, then report one block complete.
    task automatic finish_block(input logic err);
        repeat (2) @(negedge clk);
        sd_done = 1'b1; sd_error = err;
        @(negedge clk);
        sd_done = 1'b0; sd_error = 1'b0;
    endtask

    // Request a burst, answer each block, check addresses, direction and the single done.
    task automatic run_burst(input string tag, input logic port, input logic wr,
                             input logic [15:0] blk, input logic [3:0] cnt,
                             input int err_blk, output int n_starts);
        int  dones;
        bit  got;
        bit  ended;
        n_starts = 0; dones = 0; got = 1'b0; ended = 1'b0;
        set_req(port, 1'b1, wr, blk, cnt);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = grant_of(port);
        end
        check_eq({tag, "_grant"}, {31'd0, got}, 32'd1);
        set_req(port, 1'b0, 1'b0, 16'h0, 4'h0);
        if (!got) return;
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int b = 0; b <= int'(cnt) && !ended; b++) begin
            check_eq({tag, "_start"}, {31'd0, sd_start}, 32'd1);
            check_eq({tag, "_addr"}, sd_addr, {7'd0, 16'(blk + 16'(b)), 9'd0});
            check_eq({tag, "_write"}, {31'd0, sd_write}, {31'd0, wr});
            addr_log[b] = sd_addr;
            n_starts++;
            @(negedge clk);
            check_eq({tag, "_start_pulse"}, {31'd0, sd_start}, 32'd0);
            finish_block(b == err_blk);
            dones += int'(done_of(port));
            if (b == err_blk || b == int'(cnt)) begin
                ended = 1'b1;
                check_eq({tag, "_done"}, {31'd0, done_of(port)}, 32'd1);
                check_eq({tag, "_error"}, {31'd0, error_of(port)}, {31'd0, b == err_blk});
                check_eq({tag, "_other_done"}, {31'd0, done_of(~port)}, 32'd0);
                check_eq({tag, "_no_start"}, {31'd0, sd_start}, 32'd0);
            end
        end
        @(negedge clk);
        dones += int'(done_of(port));
        check_eq({tag, "_idle"}, {30'd0, busy, sd_start}, 32'd0);
        check_eq({tag, "_ndone"}, dones, 32'd1);
    endtask

    int  n;
    int  k;
    int  stray;

    initial begin
        reset = 1'b1; sd_done = 1'b0; sd_error = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        repeat (3) @(negedge clk);
        check_eq("rst_grants", {30'd0, req0_grant, req1_grant}, 32'd0);
        check_eq("rst_dones", {28'd0, req0_done, req1_done, req0_error, req1_error}, 32'd0);
        check_eq("rst_sd", {30'd0, sd_start, sd_write}, 32'd0);
        check_eq("rst_addr", sd_addr, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // Both valid out of reset: port 0 first, then port 1
        set_req(1'b0, 1'b1, 1'b0, 16'h0001, 4'h0);
        set_req(1'b1, 1'b1, 1'b1, 16'h0002, 4'h0);
        @(negedge clk);
        check_eq("arb1_grant", {30'd0, req0_grant, req1_grant}, 32'd2);
        check_eq("arb1_addr", sd_addr, 32'h0000_0200);
        check_eq("arb1_start", {31'd0, sd_start}, 32'd1);
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        finish_block(1'b0);
        check_eq("arb1_done", {30'd0, req0_done, req0_error}, 32'd2);
        @(negedge clk);
        check_eq("arb1_gap", {30'd0, busy, req1_grant}, 32'd0);
        @(negedge clk);
        check_eq("arb2_grant", {30'd0, req0_grant, req1_grant}, 32'd1);
        check_eq("arb2_addr", sd_addr, 32'h0000_0400);
        check_eq("arb2_write", {31'd0, sd_write}, 32'd1);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        finish_block(1'b0);
        check_eq("arb2_done", {30'd0, req1_done, req1_error}, 32'd2);
        // Tie again right after port 1 was served: port 0 wins
        set_req(1'b0, 1'b1, 1'b0, 16'h0003, 4'h0);
        set_req(1'b1, 1'b1, 1'b0, 16'h0004, 4'h0);
        repeat (2) @(negedge clk);
        check_eq("arb3_grant", {30'd0, req0_grant, req1_grant}, 32'd2);
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        finish_block(1'b0);
        repeat (2) @(negedge clk);
        check_eq("arb4_grant", {30'd0, req0_grant, req1_grant}, 32'd1);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        finish_block(1'b0);
        check_eq("arb4_done", {31'd0, req1_done}, 32'd1);
        repeat (2) @(negedge clk);

        run_burst("single", 1'b0, 1'b0, 16'h0010, 4'd0, -1, n);
        check_eq("single_addr0", addr_log[0], 32'h0000_2000);
        check_eq("single_nstart", n, 32'd1);

        run_burst("burst", 1'b1, 1'b1, 16'h0003, 4'd2, -1, n);
        check_eq("burst_addr0", addr_log[0], 32'h0000_0600);
        check_eq("burst_addr1", addr_log[1], 32'h0000_0800);
        check_eq("burst_addr2", addr_log[2], 32'h0000_0A00);
        check_eq("burst_nstart", n, 32'd3);

        run_burst("wrap", 1'b0, 1'b0, 16'hFFFF, 4'd1, -1, n);
        check_eq("wrap_addr0", addr_log[0], 32'h01FF_FE00);
        check_eq("wrap_addr1", addr_log[1], 32'h0000_0000);

        run_burst("err", 1'b1, 1'b1, 16'h0100, 4'd3, 1, n);
        check_eq("err_nstart", n, 32'd2);

        // No sd_done at all: the 4-bit watchdog aborts 15 cycles after start
        set_req(1'b0, 1'b1, 1'b0, 16'h0005, 4'h0);
        @(negedge clk);
        check_eq("wd_grant", {31'd0, req0_grant}, 32'd1);
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        k = 0;
        for (int i = 1; i <= 30 && k == 0; i++) begin
            @(negedge clk);
            if (req0_done) k = i;
        end
        check_eq("wd_cycles", k, 32'd15);
        check_eq("wd_error", {31'd0, req0_error}, 32'd1);
        @(negedge clk);
        check_eq("wd_idle", {31'd0, busy}, 32'd0);

        // Reset while waiting on a block
        set_req(1'b1, 1'b1, 1'b0, 16'h0040, 4'h3);
        @(negedge clk);
        check_eq("rstw_grant", {31'd0, req1_grant}, 32'd1);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rstw_busy", {31'd0, busy}, 32'd0);
        stray = int'(req1_done) + int'(sd_start);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            stray += int'(req1_done) + int'(req0_done) + int'(sd_start);
        end
        check_eq("rstw_quiet", stray, 32'd0);
        run_burst("after_rst", 1'b0, 1'b0, 16'h0020, 4'd0, -1, n);
        check_eq("after_rst_addr", addr_log[0], 32'h0000_4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
